// File: rtl/imm_ext_queue_if.sv
// Handshake bundle for imm_ext_queue: producer side (in_*, flush),
// consumer side (out_*), and the completed-pop counter ext_cnt.
interface imm_ext_queue_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      ext_cnt;

  modport slave (
    input  in_valid,
    input  in_imm,
    input  in_op,
    input  in_tag,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_tag,
    output ext_cnt
  );

  modport master (
    output in_valid,
    output in_imm,
    output in_op,
    output in_tag,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  ext_cnt
  );
endinterface

// File: rtl/imm_ext_queue.sv
// Immediate extender feeding a 2-entry FIFO; extension is done at push.
// Ports: clk, reset (sync, active-high), q (imm_ext_queue_if.slave).
// Op 0 sext, 1 zext, 2 upper-align, 3 branch offset or zero.
// Macro IMM_EXT_BRANCH_SHIFT_EN: op 3 gives sext(imm) << 2.
module imm_ext_queue #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  imm_ext_queue_if.slave q
);

  logic [OUT_W-1:0] data_q [2];
  logic [OUT_W-1:0] data_d [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [TAG_W-1:0] tag_d  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      ext_cnt_q, ext_cnt_d;

  logic signed [IN_W-1:0]  simm;
  logic        [OUT_W-1:0] sext;
  logic        [OUT_W-1:0] zext;
  logic        [OUT_W-1:0] ext;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.out_data  = empty ? '0 : data_q[rd_ptr_q];
  assign q.out_tag   = empty ? '0 : tag_q[rd_ptr_q];
  assign q.ext_cnt   = ext_cnt_q;

  assign push = q.in_valid && !full;
  assign pop  = !empty && q.out_ready;

  // Size casts keep the operand's signedness, so simm widens with its sign.
  assign simm = q.in_imm;
  assign sext = OUT_W'(simm);
  assign zext = OUT_W'(q.in_imm);

  always_comb begin
    ext = '0;
    unique case (q.in_op)
      2'd0: ext = sext;
      2'd1: ext = zext;
      2'd2: ext = zext << (OUT_W - IN_W);
      2'd3: begin
`ifdef IMM_EXT_BRANCH_SHIFT_EN
        ext = sext << 2;
`else
        ext = '0;
`endif
      end
      default: ext = '0;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    tag_d     = tag_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ext_cnt_d = ext_cnt_q + 32'(pop);
    if (q.flush) begin
      // Same-edge push is dropped; a same-edge pop still counted above.
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = ext;
        tag_d[wr_ptr_q]  = q.in_tag;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      ext_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ext_cnt_q <= ext_cnt_d;
    end
  end

  // Payload needs no reset: it is masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule
